// File: rtl/mac_layer_ctrl.sv
// Layer controller for the 64-lane mac datapath: streams chunk addresses per neuron,
// accumulates the mac results with saturation and writes one value per neuron.
module mac_layer_ctrl #(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_CHUNKS  = 13,
    parameter int MAC_LATENCY = 2,
    parameter int DADDR_W     = 4,
    parameter int WADDR_W     = 8,
    parameter int OADDR_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               mem_re,
    output logic [DADDR_W-1:0] data_addr,
    output logic [WADDR_W-1:0] weight_addr,
    input  logic [15:0]        mac_result,
    output logic               out_we,
    output logic [OADDR_W-1:0] out_addr,
    output logic [15:0]        out_data
);

    localparam int D   = 1 + MAC_LATENCY;
    localparam int DCW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [DADDR_W-1:0] k;
    logic [DADDR_W-1:0] k_hold;
    logic [WADDR_W-1:0] w;
    logic [WADDR_W-1:0] w_hold;
    logic [OADDR_W-1:0] n;
    logic [DCW-1:0]     dcnt;
    logic [15:0]        acc;
    logic [D-1:0]       tag;
    logic [16:0]        sum;
    logic               last_chunk;
    logic               last_neuron;
    logic               last_drain;

    assign last_chunk  = (k == DADDR_W'(NUM_CHUNKS - 1));
    assign last_neuron = (n == OADDR_W'(NUM_NEURONS - 1));
    assign last_drain  = (dcnt == DCW'(D - 1));
    assign sum         = {1'b0, acc} + {1'b0, mac_result};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (last_chunk) state_next = DRAIN;
            DRAIN:   if (last_drain) state_next = WRITE;
            WRITE:   state_next = last_neuron ? DONE : FETCH;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The running weight address walks n*NUM_CHUNKS+k without a multiplier, since
    // every neuron's FETCH follows straight on from the previous one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k      <= '0;
            k_hold <= '0;
            w      <= '0;
            w_hold <= '0;
            n      <= '0;
            dcnt   <= '0;
            acc    <= '0;
            tag    <= '0;
        end else begin
            tag[0] <= mem_re;
            for (int i = 1; i < D; i++) tag[i] <= tag[i-1];
            if (tag[D-1]) acc <= sum[16] ? 16'hFFFF : sum[15:0];
            case (state)
                IDLE: begin
                    if (start) begin
                        k    <= '0;
                        w    <= '0;
                        n    <= '0;
                        acc  <= '0;
                        dcnt <= '0;
                    end
                end
                FETCH: begin
                    k_hold <= k;
                    w_hold <= w;
                    w      <= w + 1'b1;
                    dcnt   <= '0;
                    if (!last_chunk) k <= k + 1'b1;
                end
                DRAIN: dcnt <= dcnt + 1'b1;
                WRITE: begin
                    acc <= '0;
                    k   <= '0;
                    if (!last_neuron) n <= n + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign mem_re      = (state == FETCH);
    assign out_we      = (state == WRITE);
    assign data_addr   = mem_re ? k : k_hold;
    assign weight_addr = mem_re ? w : w_hold;
    assign out_addr    = out_we ? n : '0;
    assign out_data    = out_we ? acc : '0;

endmodule

// File: tb/tb_mac_layer_ctrl.sv
// Directed bench for mac_layer_ctrl: memory/mac model, layer timing, addresses,
// saturation, ignored start, mid-layer reset and a minimal configuration.
module tb_mac_layer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        start2;
    logic        busy, done, mem_re, out_we;
    logic [3:0]  data_addr, out_addr;
    logic [7:0]  weight_addr;
    logic [15:0] mac_result, out_data;
    logic        busy2, done2, mem_re2, out_we2;
    logic [3:0]  data_addr2, out_addr2;
    logic [7:0]  weight_addr2;
    logic [15:0] mac_result2, out_data2;

    mac_layer_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .mem_re(mem_re), .data_addr(data_addr), .weight_addr(weight_addr),
        .mac_result(mac_result), .out_we(out_we), .out_addr(out_addr), .out_data(out_data)
    );

    mac_layer_ctrl #(.NUM_NEURONS(1), .NUM_CHUNKS(1), .MAC_LATENCY(0)) dut_small (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .mem_re(mem_re2), .data_addr(data_addr2), .weight_addr(weight_addr2),
        .mac_result(mac_result2), .out_we(out_we2), .out_addr(out_addr2), .out_data(out_data2)
    );

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    // Memory read register followed by the mac delay line; 0x5555 marks an invalid slot.
    logic [15:0] chunk_val [0:255];
    logic [15:0] mem_q = '0, mac_p1 = '0, mac_p2 = '0, mem2_q = '0;
    always @(posedge clk) begin
        mem_q  <= mem_re ? chunk_val[weight_addr] : 16'h5555;
        mac_p1 <= mem_q;
        mac_p2 <= mac_p1;
        mem2_q <= mem_re2 ? 16'h0123 : 16'h5555;
    end
    assign mac_result  = mac_p2;
    assign mac_result2 = mem2_q;

    int vectors = 0;
    int miscompares = 0;
    int we_cyc[$], we_addr[$], we_data[$], rd_d[$], rd_w[$], re_per[$];
    int re_run, done_cnt, done_cyc, t0;
    bit mon_en = 1'b0;
    int exp_data [10];

    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (mem_re) begin
                rd_d.push_back(int'(data_addr));
                rd_w.push_back(int'(weight_addr));
                re_run++;
            end
            if (out_we) begin
                we_cyc.push_back(tick - t0);
                we_addr.push_back(int'(out_addr));
                we_data.push_back(int'(out_data));
                re_per.push_back(re_run);
                re_run = 0;
            end
            if (done) begin
                done_cnt++;
                done_cyc = tick - t0;
            end
        end
    end

    task automatic checkOutput(input string name, input int got, input int expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expected);
        end
    endtask

    task automatic clearLogs();
        we_cyc.delete(); we_addr.delete(); we_data.delete();
        rd_d.delete(); rd_w.delete(); re_per.delete();
        re_run = 0; done_cnt = 0; done_cyc = -1;
    endtask

    // Runs one layer from a start in cycle 0; extra start pulses go in cycles p1 and p2.
    task automatic applyStimulus(input int p1, input int p2);
        clearLogs();
        @(negedge clk);
        start  = 1'b1;
        t0     = tick;
        mon_en = 1'b1;
        for (int c = 1; c < 400 && done_cnt == 0; c++) begin
            @(negedge clk);
            start = (c == p1) || (c == p2);
        end
        start = 1'b0;
        checkOutput("done_seen", int'(done_cnt > 0), 1);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
    endtask

    task automatic checkLayer(input string name);
        checkOutput({name, "_we_count"}, we_cyc.size(), 10);
        checkOutput({name, "_done_count"}, done_cnt, 1);
        checkOutput({name, "_done_cycle"}, done_cyc, 171);
        for (int i = 0; i < 10 && i < we_cyc.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", name, i), we_addr[i], i);
            checkOutput($sformatf("%s_data%0d", name, i), we_data[i], exp_data[i]);
            checkOutput($sformatf("%s_cyc%0d", name, i), we_cyc[i], 17 * (i + 1));
        end
    endtask

    task automatic checkIdleOutputs(input string name);
        checkOutput({name, "_busy"}, int'(busy), 0);
        checkOutput({name, "_done"}, int'(done), 0);
        checkOutput({name, "_mem_re"}, int'(mem_re), 0);
        checkOutput({name, "_data_addr"}, int'(data_addr), 0);
        checkOutput({name, "_weight_addr"}, int'(weight_addr), 0);
        checkOutput({name, "_out_we"}, int'(out_we), 0);
        checkOutput({name, "_out_addr"}, int'(out_addr), 0);
        checkOutput({name, "_out_data"}, int'(out_data), 0);
    endtask

    initial begin
        int we2_cnt, we2_cyc, we2_data, done2_cnt, done2_cyc, t2;
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        for (int i = 0; i < 256; i++) chunk_val[i] = 16'h0001;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_busy2", int'(busy2), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] layer with unit chunk results");
        for (int i = 0; i < 10; i++) exp_data[i] = 13;
        applyStimulus(-1, -1);
        checkLayer("unit");
        checkOutput("rd_count", rd_w.size(), 130);
        for (int k = 0; k < 13 && 26 + k < rd_w.size(); k++)
            checkOutput($sformatf("waddr_n2_k%0d", k), rd_w[26 + k], 26 + k);
        for (int i = 0; i < rd_d.size(); i++)
            checkOutput($sformatf("daddr_%0d", i), rd_d[i], i % 13);
        for (int i = 0; i < re_per.size(); i++)
            checkOutput($sformatf("re_cycles_n%0d", i), re_per[i], 13);
        checkOutput("idle_after_layer", int'(busy), 0);
        checkOutput("addr_hold", int'(data_addr), 12);

        $display("[TB] saturation layer");
        for (int i = 0; i < 256; i++) chunk_val[i] = 16'h0000;
        chunk_val[0]  = 16'h8000; chunk_val[1]  = 16'h9000;
        chunk_val[13] = 16'h0005;
        chunk_val[26] = 16'h8000; chunk_val[27] = 16'h7FFF;
        chunk_val[39] = 16'h0001; chunk_val[40] = 16'hFFFF;
        chunk_val[52] = 16'h1234; chunk_val[64] = 16'h0100;
        for (int i = 0; i < 10; i++) exp_data[i] = 0;
        exp_data[0] = 16'hFFFF;
        exp_data[1] = 5;
        exp_data[2] = 16'hFFFF;
        exp_data[3] = 16'hFFFF;
        exp_data[4] = 16'h1334;
        applyStimulus(-1, -1);
        checkLayer("sat");

        $display("[TB] start pulses while busy");
        for (int i = 0; i < 256; i++) chunk_val[i] = 16'h0001;
        for (int i = 0; i < 10; i++) exp_data[i] = 13;
        applyStimulus(5, 100);
        checkLayer("ignored_start");

        $display("[TB] reset mid-layer");
        clearLogs();
        @(negedge clk);
        start  = 1'b1;
        t0     = tick;
        mon_en = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (38) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_reset_mem_re", int'(mem_re), 1);
        checkOutput("pre_reset_waddr", int'(weight_addr), 31);
        reset = 1'b1;
        #1;
        checkIdleOutputs("abort");
        clearLogs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("abort_we_count", we_cyc.size(), 0);
        checkOutput("abort_done_count", done_cnt, 0);
        mon_en = 1'b0;
        applyStimulus(-1, -1);
        checkLayer("after_abort");

        $display("[TB] minimal configuration");
        we2_cnt = 0; we2_cyc = -1; we2_data = -1; done2_cnt = 0; done2_cyc = -1;
        @(negedge clk);
        start2 = 1'b1;
        t2     = tick;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (out_we2) begin
                we2_cnt++;
                we2_cyc  = tick - t2;
                we2_data = int'(out_data2);
            end
            if (done2) begin
                done2_cnt++;
                done2_cyc = tick - t2;
            end
        end
        checkOutput("small_we_count", we2_cnt, 1);
        checkOutput("small_we_cycle", we2_cyc, 3);
        checkOutput("small_data", we2_data, 16'h0123);
        checkOutput("small_done_count", done2_cnt, 1);
        checkOutput("small_done_cycle", done2_cyc, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
